// File: rtl/uart_rx_pkg.sv
// UART receive controller: shared types and constants.
// Imported by the tick counter and the RX controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MIN_PRESCALE = 8;

    function automatic logic prescale_ok(input int p);
        return (p >= MIN_PRESCALE) && (p % 2 == 0);
    endfunction

endpackage

// File: rtl/uart_rx_tick_counter.sv
// Oversampling edge counter (wraps at P-1) and bit counter.
// Both counters clear synchronously while the receiver rests in IDLE.
module uart_rx_tick_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  bit_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  edge_last,
    output logic [BIT_W-1:0]      bit_cnt
);

    assign edge_last = (edge_cnt == prescale - 1'b1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            edge_cnt <= edge_last ? '0 : edge_cnt + 1'b1;
            if (bit_en)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, 3-sample majority vote,
// LSB-first deserialiser, parity and stop checking.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e state, state_nx;

    logic [PRESCALE_W-1:0] p_lat;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] smp_lo;
    logic [PRESCALE_W-1:0] smp_dec;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  edge_last;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_last;
    logic                  at_dec;
    logic                  start_go;
    logic                  s_a, s_b, maj;
    logic                  exp_par;
    logic                  par_pend;
    logic [DATA_WIDTH-1:0] shreg;

    assign half     = p_lat >> 1;
    assign smp_lo   = half - 1'b1;
    assign smp_dec  = half + 1'b1;
    assign at_dec   = (edge_cnt == smp_dec);
    assign bit_last = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign start_go = (state == IDLE) && !RX_IN
                    && prescale_ok(int'(Prescale));

    // Third vote taken straight from the line to decide on edge h+1
    assign maj = (s_a & s_b) | (s_a & RX_IN) | (s_b & RX_IN);

    assign exp_par = (PAR_TYP == PAR_EVEN) ? ^shreg : ~^shreg;

    uart_rx_tick_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_tick (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (state_nx == IDLE),
        .prescale  (p_lat),
        .bit_en    ((state == DATA) && edge_last),
        .edge_cnt  (edge_cnt),
        .edge_last (edge_last),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (start_go)
                    state_nx = START;
            START:
                if (at_dec && maj)
                    state_nx = IDLE;
                else if (edge_last)
                    state_nx = DATA;
            DATA:
                if (edge_last && bit_last)
                    state_nx = PAR_EN ? PARITY : STOP;
            PARITY:
                if (edge_last)
                    state_nx = STOP;
            STOP:
                // Leave half a bit early so a back-to-back start is seen
                if (at_dec)
                    state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_lat      <= PRESCALE_W'(MIN_PRESCALE);
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            shreg      <= '0;
            par_pend   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            busy       <= (state_nx != IDLE);
            if (start_go) begin
                p_lat    <= Prescale;
                par_pend <= 1'b0;
            end
            if (edge_cnt == smp_lo)
                s_a <= RX_IN;
            if (edge_cnt == half)
                s_b <= RX_IN;
            if ((state == DATA) && at_dec)
                shreg[bit_cnt] <= maj;
            if ((state == PARITY) && at_dec && (maj != exp_par))
                par_pend <= 1'b1;
            if ((state == STOP) && at_dec) begin
                par_err <= par_pend;
                stp_err <= ~maj;
                if (maj && !par_pend) begin
                    P_DATA     <= shreg;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl.
// Frames are driven bit by bit; outputs sampled away from the clock edge.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int t0 = 0;
    int dv_cnt = 0;
    int dv_cyc = -1;
    int n0;
    logic [7:0] dv_q[$];
    logic busy_seen = 1'b0;

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc - t0;
            dv_q.push_back(P_DATA);
        end
        if (busy)
            busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n, input int flip_at);
        for (int e = 0; e < n; e++) begin
            RX_IN = (e == flip_at) ? ~v : v;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_per(input int k);
        while (cyc - t0 < k)
            @(negedge CLK);
    endtask

    task automatic send_frame(input int p, input logic [7:0] d,
                              input logic pflip, input logic stop_v,
                              input int flip_bit);
        logic pb;
        t0 = cyc;
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++)
            drive_bit(d[i], p, (i == flip_bit) ? p / 2 : -1);
        if (PAR_EN) begin
            pb = (^d) ^ PAR_TYP ^ pflip;
            drive_bit(pb, p, -1);
        end
        if (stop_v)
            drive_bit(1'b1, p, -1);
        else
            drive_bit(1'b0, p / 2 + 2, -1);
        RX_IN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1);
    end

    initial begin
        RST = 1'b0;
        RX_IN = 1'b1;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Prescale = 6'd8;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_dv", data_valid, 1'b0);
        chk("rst_par", par_err, 1'b0);
        chk("rst_stp", stp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        RST = 1'b1;
        idle(4);

        // P=8 8N1 0xA5, data_valid expected in cycle 78
        n0 = dv_cnt;
        send_frame(8, 8'hA5, 1'b0, 1'b1, -1);
        idle(4);
        chk("a5_cnt", dv_cnt, n0 + 1);
        chk("a5_cyc", dv_cyc, 78);
        chk("a5_data", P_DATA, 8'hA5);
        chk("a5_par", par_err, 1'b0);
        chk("a5_stp", stp_err, 1'b0);
        chk("a5_busy", busy, 1'b0);

        // P=16 8E1 0x3C, data_valid expected in cycle 170
        Prescale = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        n0 = dv_cnt;
        send_frame(16, 8'h3C, 1'b0, 1'b1, -1);
        idle(4);
        chk("e3c_cnt", dv_cnt, n0 + 1);
        chk("e3c_cyc", dv_cyc, 170);
        chk("e3c_data", P_DATA, 8'h3C);
        chk("e3c_par", par_err, 1'b0);

        // P=16 8O1 0x01
        PAR_TYP = 1'b1;
        n0 = dv_cnt;
        send_frame(16, 8'h01, 1'b0, 1'b1, -1);
        idle(4);
        chk("o01_cnt", dv_cnt, n0 + 1);
        chk("o01_data", P_DATA, 8'h01);
        chk("o01_par", par_err, 1'b0);

        // 8E1 with parity bit flipped
        PAR_TYP = 1'b0;
        n0 = dv_cnt;
        send_frame(16, 8'h3C, 1'b1, 1'b1, -1);
        idle(4);
        chk("perr_cnt", dv_cnt, n0);
        chk("perr_par", par_err, 1'b1);
        chk("perr_stp", stp_err, 1'b0);
        chk("perr_data", P_DATA, 8'h01);

        // 8N1 with stop bit low
        PAR_EN = 1'b0;
        n0 = dv_cnt;
        send_frame(16, 8'h77, 1'b0, 1'b0, -1);
        idle(20);
        chk("serr_cnt", dv_cnt, n0);
        chk("serr_stp", stp_err, 1'b1);
        chk("serr_par", par_err, 1'b0);
        chk("serr_data", P_DATA, 8'h01);

        // good frame clears stp_err
        n0 = dv_cnt;
        send_frame(16, 8'h96, 1'b0, 1'b1, -1);
        idle(4);
        chk("clr_cnt", dv_cnt, n0 + 1);
        chk("clr_stp", stp_err, 1'b0);
        chk("clr_data", P_DATA, 8'h96);

        // 3-cycle start glitch at P=8
        Prescale = 6'd8;
        n0 = dv_cnt;
        t0 = cyc;
        drive_bit(1'b0, 3, -1);
        RX_IN = 1'b1;
        wait_per(5);
        chk("gl_busy5", busy, 1'b1);
        wait_per(6);
        chk("gl_busy6", busy, 1'b0);
        idle(10);
        chk("gl_cnt", dv_cnt, n0);
        chk("gl_data", P_DATA, 8'h96);
        chk("gl_stp", stp_err, 1'b0);

        // one-cycle flip at edge h of data bit 3
        n0 = dv_cnt;
        send_frame(8, 8'h5A, 1'b0, 1'b1, 3);
        idle(4);
        chk("mv_cnt", dv_cnt, n0 + 1);
        chk("mv_data", P_DATA, 8'h5A);

        // back-to-back frames at P=32
        Prescale = 6'd32;
        n0 = dv_cnt;
        dv_q.delete();
        send_frame(32, 8'h55, 1'b0, 1'b1, -1);
        send_frame(32, 8'hAA, 1'b0, 1'b1, -1);
        idle(4);
        chk("b2b_cnt", dv_cnt, n0 + 2);
        chk("b2b_w0", (dv_q.size() > 0) ? dv_q[0] : 8'hxx, 8'h55);
        chk("b2b_w1", (dv_q.size() > 1) ? dv_q[1] : 8'hxx, 8'hAA);

        // illegal prescale: line ignored
        Prescale = 6'd7;
        n0 = dv_cnt;
        busy_seen = 1'b0;
        send_frame(8, 8'h0F, 1'b0, 1'b1, -1);
        idle(4);
        chk("ill_busy", busy_seen, 1'b0);
        chk("ill_cnt", dv_cnt, n0);
        chk("ill_data", P_DATA, 8'hAA);

        // reset mid-DATA, then a clean frame
        Prescale = 6'd8;
        t0 = cyc;
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 8, -1);
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 3, -1);
        RST = 1'b0;
        @(negedge CLK);
        chk("mr_pdata", P_DATA, 8'h00);
        chk("mr_busy", busy, 1'b0);
        chk("mr_dv", data_valid, 1'b0);
        chk("mr_par", par_err, 1'b0);
        chk("mr_stp", stp_err, 1'b0);
        RX_IN = 1'b1;
        idle(2);
        RST = 1'b1;
        idle(4);
        n0 = dv_cnt;
        send_frame(8, 8'hC3, 1'b0, 1'b1, -1);
        idle(4);
        chk("mr2_cnt", dv_cnt, n0 + 1);
        chk("mr2_data", P_DATA, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART: sequences an oversampling edge/bit counter, majority-votes each bit, deserialises data LSB-first and checks start, parity and stop bits. Sits between the synchronised serial input and the RX FIFO/register-file write path. Runs entirely in the UART RX clock domain and delivers one parallel word per valid frame.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of Prescale and the edge counter.
- CLK  in  1  RX clock, oversampling rate = Prescale × baud.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high, already synchronised to CLK.
- PAR_EN  in  1  1 = parity bit present after data.
- PAR_TYP  in  1  0 = even, 1 = odd.
- Prescale  in  PRESCALE_W  oversampling ratio; legal values are even and ≥ 8.
- P_DATA  out  DATA_WIDTH  last good word; reset 0.
- data_valid  out  1  one-cycle pulse with new P_DATA; reset 0.
- par_err  out  1  parity result of last completed frame; reset 0.
- stp_err  out  1  stop-bit result of last completed frame; reset 0.
- busy  out  1  high in any state except IDLE; reset 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset → IDLE, counters 0, shift register 0.
- P = Prescale latched on IDLE→START; mid-frame Prescale changes are ignored. h = P/2.
- IDLE: edge counter held at 0. RX_IN = 0 and latched-legal Prescale → START; the detecting cycle counts as edge 0. Illegal Prescale (odd or < 8): stay IDLE, RX_IN ignored.
- Edge counter runs 0..P-1 per bit, wraps to 0 at P-1 and advances bit counter (DATA state only).
- Sampling: RX_IN captured at edges h-1, h, h+1; majority of the three forms bit value at edge h+1 (the third sample is used directly, not registered first).
- START: at edge h+1, bit value 1 → glitch, return to IDLE, no outputs change. Bit value 0 → continue; at edge P-1 → DATA.
- DATA: bit value shifted into bit position bit_cnt (LSB first) at edge h+1. At edge P-1 of bit DATA_WIDTH-1 → PARITY if PAR_EN else STOP.
- PARITY: expected = XOR(data) for even, its inverse for odd; mismatch at edge h+1 records pending parity error. Edge P-1 → STOP.
- STOP: at edge h+1, go IDLE immediately (half-bit early to allow back-to-back frames) and update par_err = pending parity error, stp_err = (bit value == 0).
- data_valid = 1 and P_DATA loaded only if stop bit = 1 and no parity error; otherwise P_DATA holds previous value.
- Pending parity error cleared on IDLE→START.
- RST asserted mid-frame: all outputs and state return to reset values immediately; partial word is discarded.

## Timing
- All outputs registered; changes appear the cycle after the deciding clock edge.
- Cycle 0 = IDLE cycle where RX_IN first seen low. Stop-bit decision edge at cycle (1+DATA_WIDTH+PAR_EN)·P + h + 1; data_valid high one cycle later, for exactly one cycle.
- P=8, 8N1: decision at cycle 77, data_valid in cycle 78. P=16, 8E1: decision 169, data_valid 170.
- Earliest next start detection: cycle after the stop decision edge.
- par_err/stp_err update in the same cycle data_valid would; held until next frame completion.
- busy rises the cycle after cycle 0 and falls with the STOP→IDLE transition.

## Structure
- uart_rx_pkg: state enum, PAR_EVEN/PAR_ODD constants, MIN_PRESCALE = 8.
- Sub-module uart_rx_tick_counter: edge counter (PRESCALE_W) with synchronous clear and wrap at P-1, plus bit counter ($clog2(DATA_WIDTH)) with enable; FSM, voter, shifter, checkers in uart_rx_ctrl.

## Test plan
- P=8, 8N1, byte 0xA5 → P_DATA=0xA5, data_valid pulse in cycle 78, par_err=stp_err=0.
- P=16, 8E1 and 8O1, bytes 0x3C and 0x01 with correct parity → valid; flipped parity bit → par_err=1, no data_valid, P_DATA unchanged.
- Stop bit driven 0 → stp_err=1, no data_valid; following good frame clears stp_err.
- 3-cycle low glitch in IDLE (P=8) → return to IDLE at start edge h+1, no outputs change; single-cycle flip at edge h of a data bit → majority vote gives correct byte.
- Two back-to-back 8N1 frames 0x55, 0xAA at P=32 with no idle gap → two data_valid pulses, both correct.
- Prescale=7 → RX_IN ignored, busy stays 0; RST pulsed mid-DATA → all outputs 0, next frame decodes correctly.
